pwm_capture: RTL

Measures an incoming PWM waveform and reports its high time and period, both counted in `sys_clk` cycles. It is the receive-side counterpart of the team's PWM generator. Typical uses are loop-back checking of generated PWM channels and reading externally driven PWM inputs such as servo feedback or fan tachometers. It sits on the peripheral bus side of the design and hands each completed measurement to the consumer through a valid/ready handshake.

---
 rtl/pwm_capture_if.sv | 24 ++
 rtl/pwm_capture.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_if.sv
// Result channel of pwm_capture: measured high time and period, handed over with valid/ready.
// The producer holds data and valid until a cycle with valid & ready.
interface pwm_capture_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [COUNT_WIDTH-1:0] high_count;
    logic [COUNT_WIDTH-1:0] period_count;
    logic                   valid;
    logic                   ready;

    modport master (
        output high_count,
        output period_count,
        output valid,
        input  ready
    );

    modport slave (
        input  high_count,
        input  period_count,
        input  valid,
        output ready
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM high-time/period meter; result valid 1 cycle after the closing rise is detected, held until ready, overwrite sets overrun.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to ignore input pulses shorter than 3 cycles (edge latency +2, widths unchanged).
module pwm_capture #(
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  pwm_in,
    pwm_capture_if.master         res,
    output logic                  overrun,
    output logic                  stalled
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   raw;
    logic                   s;
    logic                   s_d_q;
    logic                   rise;
    logic                   fall;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] hi_lat_q, hi_lat_d;
    logic                   meas;
    logic                   stall_set;

    logic [COUNT_WIDTH-1:0] high_q, high_d;
    logic [COUNT_WIDTH-1:0] period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   stalled_q, stalled_d;
    logic                   xfer;
    logic                   ovr_set;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign raw = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // The filtered level follows the synchronized input only once the current and
    // two previous samples agree, so 1- and 2-cycle pulses never reach the FSM.
    logic [1:0] hist_q;
    logic       flt_q;

    always_comb begin
        s = flt_q;
        if ((raw == hist_q[0]) && (raw == hist_q[1])) begin
            s = raw;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            flt_q  <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], raw};
            flt_q  <= s;
        end
    end
`else
    assign s = raw;
`endif

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            s_d_q <= 1'b0;
        end else begin
            s_d_q <= s;
        end
    end

    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    // Saturation is checked before edges so a counter at all-ones never yields a result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_lat_d  = hi_lat_q;
        meas      = 1'b0;
        stall_set = 1'b0;
        if (!enable) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            hi_lat_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == CNT_MAX) begin
                        stall_set = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_ARM;
                    end else if (fall) begin
                        hi_lat_d = cnt_q;
                        cnt_d    = cnt_q + CNT_ONE;
                        state_d  = ST_LOW;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (cnt_q == CNT_MAX) begin
                        stall_set = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_ARM;
                    end else if (rise) begin
                        meas    = 1'b1;
                        cnt_d   = CNT_ONE;
                        state_d = ST_HIGH;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_lat_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_lat_q <= hi_lat_d;
        end
    end

    // A new result always wins the register; overrun set beats the clear from a transfer.
    always_comb begin
        xfer      = valid_q & res.ready;
        ovr_set   = meas & valid_q & ~res.ready;
        valid_d   = meas | (valid_q & ~xfer);
        overrun_d = ovr_set | (overrun_q & ~xfer);
        stalled_d = stall_set | (stalled_q & ~meas);
        high_d    = high_q;
        period_d  = period_q;
        if (meas) begin
            high_d   = hi_lat_q;
            period_d = cnt_q;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            high_q    <= high_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            stalled_q <= stalled_d;
        end
    end

    assign res.high_count   = high_q;
    assign res.period_count = period_q;
    assign res.valid        = valid_q;
    assign overrun          = overrun_q;
    assign stalled          = stalled_q;

endmodule
